// File: rtl/ntt_pkg.sv
// Shared types and modular-arithmetic helpers for the streaming NTT engine.
package ntt_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        BFLY  = 2'd1,
        DRAIN = 2'd2
    } ntt_state_e;

    function automatic int unsigned bitrev(input int unsigned idx, input int unsigned width);
        int unsigned r;
        r = 0;
        for (int unsigned b = 0; b < width; b++) begin
            r = (r << 1) | ((idx >> b) & 32'd1);
        end
        return r;
    endfunction

    function automatic int unsigned modmul(input int unsigned a, input int unsigned b,
                                           input int unsigned q);
        longint unsigned p;
        p = 64'(a) * 64'(b);
        return 32'(p % 64'(q));
    endfunction

    function automatic int unsigned modadd(input int unsigned a, input int unsigned b,
                                           input int unsigned q);
        int unsigned s;
        s = a + b;
        return (s >= q) ? s - q : s;
    endfunction

    function automatic int unsigned modsub(input int unsigned a, input int unsigned b,
                                           input int unsigned q);
        int unsigned s;
        s = a + q - b;
        return (s >= q) ? s - q : s;
    endfunction

    function automatic int unsigned modpow(input int unsigned b, input int unsigned e,
                                           input int unsigned q);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < e; i++) begin
            r = modmul(r, b, q);
        end
        return r;
    endfunction

    // Smallest g with g^n == -1 mod q, i.e. a primitive 2n-th root of unity for power-of-two n.
    function automatic int unsigned find_phi(input int unsigned n, input int unsigned q);
        for (int unsigned g = 2; g < q; g++) begin
            if (modpow(g, n, q) == q - 1) return g;
        end
        return 0;
    endfunction

endpackage

// File: rtl/ntt_twiddle_rom.sv
// Constant twiddle tables: phi^i, forward/inverse butterfly twiddles and inverse output scaling.
module ntt_twiddle_rom import ntt_pkg::*; #(
    parameter              TW_FILE = "ntt_tw.mem",
    parameter int unsigned Q       = 17,
    parameter int unsigned N       = 8,
    parameter int unsigned LOGQ    = 5,
    parameter int unsigned LOGN    = 3,
    parameter int unsigned N_INV   = 15
) (
    input  logic [LOGN-1:0] phi_idx,
    output logic [LOGQ-1:0] phi,
    input  logic [LOGN-2:0] w_idx,
    output logic [LOGQ-1:0] w_fwd,
    output logic [LOGQ-1:0] w_inv,
    input  logic [LOGN-1:0] s_idx,
    output logic [LOGQ-1:0] s
);

    // Tables are elaborated from Q and N so the image always matches the parameters.
    localparam int unsigned Phi      = find_phi(N, Q);
    localparam int unsigned PhiInv   = modpow(Phi, 2 * N - 1, Q);
    localparam int unsigned Omega    = modmul(Phi, Phi, Q);
    localparam int unsigned OmegaInv = modmul(PhiInv, PhiInv, Q);

    logic [LOGQ-1:0] phi_tab   [N];
    logic [LOGQ-1:0] s_tab     [N];
    logic [LOGQ-1:0] w_fwd_tab [N/2];
    logic [LOGQ-1:0] w_inv_tab [N/2];

    for (genvar i = 0; i < N; i++) begin : g_full
        assign phi_tab[i] = LOGQ'(modpow(Phi, i, Q));
        assign s_tab[i]   = LOGQ'(modmul(N_INV, modpow(PhiInv, i, Q), Q));
    end

    for (genvar j = 0; j < N / 2; j++) begin : g_half
        assign w_fwd_tab[j] = LOGQ'(modpow(Omega, j, Q));
        assign w_inv_tab[j] = LOGQ'(modpow(OmegaInv, j, Q));
    end

    assign phi   = phi_tab[phi_idx];
    assign s     = s_tab[s_idx];
    assign w_fwd = w_fwd_tab[w_idx];
    assign w_inv = w_inv_tab[w_idx];

endmodule

// File: rtl/ntt_stream_fwd_inv.sv
// Streaming negacyclic NTT/INTT: bit-reversed load, in-place radix-2 DIT butterflies,
// natural-order drain with optional inverse scaling.
module ntt_stream_fwd_inv import ntt_pkg::*; #(
    parameter int unsigned Q       = 17,
    parameter int unsigned N       = 8,
    parameter int unsigned LOGQ    = 5,
    parameter int unsigned LOGN    = 3,
    parameter int unsigned N_INV   = 15,
    parameter              TW_FILE = "ntt_tw.mem"
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [LOGQ-1:0] poly_in,
    input  logic            mode_inv,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LOGQ-1:0] poly_out,
    output logic            out_last,
    output logic            busy
);

    localparam int unsigned     SW        = (LOGN > 1) ? $clog2(LOGN) : 1;
    localparam logic [LOGN-1:0] CntLast   = LOGN'(N - 1);
    localparam logic [LOGN-1:0] CntHalf   = LOGN'(N / 2 - 1);
    localparam logic [SW-1:0]   StageLast = SW'(LOGN - 1);

    ntt_state_e      state_q, state_d;
    logic [LOGN-1:0] cnt_q, cnt_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic            mode_q, mode_d;
    logic            settle_q, settle_d;

    logic [LOGQ-1:0] a_q [N];

    logic [LOGQ-1:0] phi_val, w_fwd_val, w_inv_val, s_val, tw_val;
    logic [LOGN-1:0] j_idx, pos, u_idx, v_idx, tw_full, load_idx;
    logic [LOGN-2:0] w_idx;
    logic [SW-1:0]   tw_shift;
    logic [LOGQ-1:0] u_val, v_val, t_val, bu_val, bv_val, load_val, drain_val;
    logic            load_inv, load_we, bfly_we;

    ntt_twiddle_rom #(
        .TW_FILE (TW_FILE),
        .Q       (Q),
        .N       (N),
        .LOGQ    (LOGQ),
        .LOGN    (LOGN),
        .N_INV   (N_INV)
    ) u_rom (
        .phi_idx (cnt_q),
        .phi     (phi_val),
        .w_idx   (w_idx),
        .w_fwd   (w_fwd_val),
        .w_inv   (w_inv_val),
        .s_idx   (cnt_q),
        .s       (s_val)
    );

    // Butterfly j of stage s pairs u = group*2^(s+1) + pos with v = u + 2^s.
    always_comb begin
        j_idx    = {1'b0, cnt_q[LOGN-2:0]};
        pos      = j_idx & ((LOGN'(1) << stage_q) - LOGN'(1));
        u_idx    = ((j_idx >> stage_q) << (32'(stage_q) + 32'd1)) | pos;
        v_idx    = u_idx | (LOGN'(1) << stage_q);
        tw_shift = StageLast - stage_q;
        tw_full  = pos << tw_shift;
        w_idx    = tw_full[LOGN-2:0];
        load_idx = LOGN'(bitrev(32'(cnt_q), LOGN));
    end

    always_comb begin
        tw_val    = mode_q ? w_inv_val : w_fwd_val;
        u_val     = a_q[u_idx];
        v_val     = a_q[v_idx];
        t_val     = LOGQ'(modmul(32'(v_val), 32'(tw_val), Q));
        bu_val    = LOGQ'(modadd(32'(u_val), 32'(t_val), Q));
        bv_val    = LOGQ'(modsub(32'(u_val), 32'(t_val), Q));
        // Beat 0 uses the live mode bit; later beats use the copy captured with beat 0.
        load_inv  = (cnt_q == '0) ? mode_inv : mode_q;
        load_val  = load_inv ? LOGQ'(32'(poly_in) % Q)
                             : LOGQ'(modmul(32'(poly_in), 32'(phi_val), Q));
        drain_val = mode_q ? LOGQ'(modmul(32'(a_q[cnt_q]), 32'(s_val), Q)) : a_q[cnt_q];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stage_d   = stage_q;
        mode_d    = mode_q;
        settle_d  = 1'b0;
        in_ready  = (state_q == LOAD);
        busy      = (state_q != LOAD);
        out_valid = (state_q == DRAIN) && !settle_q;
        out_last  = out_valid && (cnt_q == CntLast);
        poly_out  = out_valid ? drain_val : '0;
        load_we   = in_ready && in_valid;
        bfly_we   = (state_q == BFLY);

        unique case (state_q)
            LOAD: begin
                if (in_valid) begin
                    if (cnt_q == '0) mode_d = mode_inv;
                    if (cnt_q == CntLast) begin
                        cnt_d   = '0;
                        stage_d = '0;
                        state_d = BFLY;
                    end else begin
                        cnt_d = cnt_q + LOGN'(1);
                    end
                end
            end
            BFLY: begin
                if (cnt_q == CntHalf) begin
                    cnt_d = '0;
                    if (stage_q == StageLast) begin
                        stage_d  = '0;
                        state_d  = DRAIN;
                        // One idle cycle before the first output beat.
                        settle_d = 1'b1;
                    end else begin
                        stage_d = stage_q + SW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + LOGN'(1);
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    if (cnt_q == CntLast) begin
                        cnt_d   = '0;
                        state_d = LOAD;
                    end else begin
                        cnt_d = cnt_q + LOGN'(1);
                    end
                end
            end
            default: begin
                state_d = LOAD;
                cnt_d   = '0;
                stage_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= LOAD;
            cnt_q    <= '0;
            stage_q  <= '0;
            mode_q   <= 1'b0;
            settle_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stage_q  <= stage_d;
            mode_q   <= mode_d;
            settle_q <= settle_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_we) begin
            a_q[load_idx] <= load_val;
        end
        if (bfly_we) begin
            a_q[u_idx] <= bu_val;
            a_q[v_idx] <= bv_val;
        end
    end

endmodule

// File: tb/tb_ntt_stream_fwd_inv.sv
// Scoreboard bench for ntt_stream_fwd_inv against a schoolbook negacyclic transform.
module tb_ntt_stream_fwd_inv;

    localparam int unsigned Q    = 17;
    localparam int unsigned N    = 8;
    localparam int unsigned LOGQ = 5;
    localparam int unsigned LOGN = 3;
    localparam int unsigned PHI  = 3;
    localparam int          LAT  = 13;

    typedef int unsigned vec_t [N];
    typedef struct {
        int unsigned data;
        bit          last;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            mode_inv = 1'b0;
    logic            out_ready = 1'b0;
    logic [LOGQ-1:0] poly_in = '0;
    logic            in_ready, out_valid, out_last, busy;
    logic [LOGQ-1:0] poly_out;

    int   n_tests = 0;
    int   n_fail = 0;
    int   beats = 0;
    int   cyc = 0;
    int   last_in_cyc = 0;
    bit   rdy_random = 1'b0;
    exp_t exp_q[$];

    ntt_stream_fwd_inv #(
        .Q       (Q),
        .N       (N),
        .LOGQ    (LOGQ),
        .LOGN    (LOGN),
        .N_INV   (15),
        .TW_FILE ("ntt_tw.mem")
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .poly_in   (poly_in),
        .mode_inv  (mode_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .poly_out  (poly_out),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int unsigned powm(input int unsigned b, input int unsigned e);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < e; i++) r = (r * b) % Q;
        return r;
    endfunction

    // A_k = sum_i x_i * phi^((2k+1)i) mod Q
    function automatic void ntt_ref(input vec_t x, output vec_t y);
        int unsigned acc;
        for (int k = 0; k < N; k++) begin
            acc = 0;
            for (int i = 0; i < N; i++) begin
                acc = (acc + (x[i] % Q) * powm(PHI, ((2 * k + 1) * i) % (2 * N))) % Q;
            end
            y[k] = acc;
        end
    endfunction

    task automatic send_block(input vec_t x, input bit inv, input bit gaps, input bit push,
                              input vec_t expv);
        bit ok;
        int n;
        if (push) begin
            for (int i = 0; i < N; i++) exp_q.push_back('{data: expv[i], last: (i == N - 1)});
        end
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    poly_in  = LOGQ'($urandom_range(0, 31));
                    mode_inv = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            poly_in  = LOGQ'(x[i]);
            mode_inv = (i == 0) ? inv : 1'($urandom_range(0, 1));
            ok = 1'b0;
            n  = 0;
            while (!ok && n < 500) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
                n++;
            end
            if (!ok) check("in_ready_timeout", 0, 1);
            if (i == N - 1) last_in_cyc = cyc;
        end
        in_valid = 1'b0;
        poly_in  = LOGQ'($urandom_range(0, 31));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: pops and compares on every output transfer.
    initial begin
        exp_t e;
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (out_valid && !prev_v) check("first_out_latency", cyc - last_in_cyc, LAT);
                if (out_valid && out_ready) begin
                    beats++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 32'(poly_out), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("poly_out", 32'(poly_out), e.data);
                        check("out_last", 32'(out_last), 32'(e.last));
                    end
                end
            end
            prev_v = out_valid;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_random) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t imp, ones, x, y, xr;
        int   base, n;
        for (int i = 0; i < N; i++) begin
            imp[i]  = (i == 0) ? 1 : 0;
            ones[i] = 1;
        end

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 1);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_out_last", 32'(out_last), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_poly_out", 32'(poly_out), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        rdy_random = 1'b1;

        send_block(imp, 1'b0, 1'b1, 1'b1, ones);
        send_block(ones, 1'b1, 1'b1, 1'b1, imp);

        x = imp;
        x[0] = 18;
        send_block(x, 1'b0, 1'b1, 1'b1, ones);

        for (int t = 0; t < 200; t++) begin
            for (int i = 0; i < N; i++) begin
                x[i]  = $urandom_range(0, 31);
                xr[i] = x[i] % Q;
            end
            ntt_ref(x, y);
            send_block(x, 1'b0, 1'b1, 1'b1, y);
            send_block(y, 1'b1, 1'b1, 1'b1, xr);
        end
        wait_drain();

        // Backpressure at output beat 2.
        rdy_random = 1'b0;
        out_ready  = 1'b1;
        base = beats;
        for (int i = 0; i < N; i++) x[i] = $urandom_range(0, 31);
        ntt_ref(x, y);
        send_block(x, 1'b0, 1'b0, 1'b1, y);
        n = 0;
        while (beats < base + 2 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 1);
            check("stall_poly_out", 32'(poly_out), y[2]);
            check("stall_out_last", 32'(out_last), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_drain();
        check("stall_total_beats", beats - base, N);
        rdy_random = 1'b1;

        // Asynchronous reset during butterfly stage 1.
        for (int i = 0; i < N; i++) x[i] = $urandom_range(0, 31);
        ntt_ref(x, y);
        send_block(x, 1'b0, 1'b0, 1'b0, y);
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("midreset_in_ready", 32'(in_ready), 1);
        check("midreset_out_valid", 32'(out_valid), 0);
        check("midreset_busy", 32'(busy), 0);
        check("midreset_out_last", 32'(out_last), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send_block(x, 1'b0, 1'b1, 1'b1, y);
        wait_drain();
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
